sr_pq_param: RTL
================

# sr_pq_param

Parametrised shift-register hardware priority queue holding `<key,value>` pairs in a sorted array of CAPACITY cells. Cell 0 always holds the highest-priority entry. It supports enqueue, dequeue and combined replace in one cycle each, with FIFO ordering among equal keys. Per-cell valid bits remove the need for sentinel keys, so every key value is legal. It is the drop-in queue core for the HWPQ comparison study, configurable as a min- or max-PQ per instance.

## Interface
- `KEY_WIDTH`, 8, key width in bits
- `VAL_WIDTH`, 8, value width in bits
- `CAPACITY`, 4, number of cells; must be ≥2
- `MAX_MODE`, 0, priority order: 0 = min-PQ (smaller key wins), 1 = max-PQ (larger key wins)
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enq`  in  1  enqueue request
- `kvi`  in  KEY_WIDTH+VAL_WIDTH  incoming pair, packed as {key, value}
- `deq`  in  1  dequeue request
- `kvo`  out  KEY_WIDTH+VAL_WIDTH  head pair (cell 0); 0 when empty
- `count`  out  $clog2(CAPACITY+1)  number of valid entries
- `empty`  out  1  count == 0
- `full`  out  1  count == CAPACITY
- `rej`  out  1  registered pulse: the previous cycle's request was (partly) rejected
- `drop`  out  1  registered pulse: an entry was evicted (only with the macro; otherwise tied 0)

## Operation
- **State:** cells `c[0..CAPACITY-1]`, each {valid, key, value}. Valid cells are contiguous from 0 and sorted by priority.
- **Priority:** "higher" means `<` when MAX_MODE=0 and `>` when MAX_MODE=1.
- **Ties:** a new entry goes after all existing entries with an equal key (stable FIFO).
- **Insert position:** `p` = number of valid cells whose key is higher or equal priority than `kvi.key`.
- **Enq only, not full:**
  - cells i>p load c[i-1];
  - c[p] loads kvi;
  - cells i<p hold;
  - count +1.
- **Deq only, not empty:**
  - c[i] loads c[i+1];
  - the last cell becomes invalid;
  - count −1.
  - The user samples `kvo` in the same cycle `deq` is asserted (show-ahead).
- **Enq+deq (replace), not empty:** result equals deq followed by enq.
  - `p'` is computed over cells 1..CAPACITY-1.
  - cells i<p' load c[i+1];
  - c[p'] loads kvi;
  - cells >p' hold;
  - count unchanged.
  - Legal when full.
- **Deq on empty:** ignored, rej=1. If enq is also asserted, the enqueue is performed normally and rej=1.
- **Enq only on full:** rejected, rej=1, state unchanged (but see Configuration).
- **No request:** all state holds; rej=0, drop=0.

## Timing
- Single-cycle operations; one operation per cycle, sustained.
- `kvo`, `count`, `empty`, `full` are driven combinationally from registers, so they reflect an operation from the cycle after its edge.
- `rej` and `drop` are registered and high for exactly one cycle, the cycle after the offending edge.
- **Reset:** asynchronous. While `rst`=1 and after its release:
  - all cells invalid;
  - kvo=0, count=0, empty=1, full=0, rej=0, drop=0.
- Reset asserted mid-operation discards that operation. No partial update is visible.
- The compare network is CAPACITY parallel comparators plus a thermometer-to-position decode. There is no multi-cycle path.

## Configuration
- `SR_PQ_OVERWRITE_EN` defined, enq only on full:
  - If kvi.key is strictly higher priority than the last cell's key, insert at `p`, shifting as usual, and discard the last cell. count stays CAPACITY; drop=1, rej=0.
  - Otherwise the request is rejected: rej=1, drop=0.
  - This makes the instance a bounded top-K tracker.
- Undefined: enq on full is always rejected, and `drop` is tied to 0.

## Test plan
- **Min ordering:** reset, then enq (5,A),(3,B),(9,C),(1,D). Required: kvo={1,D}, count=4, full=1. Four deqs return keys 1,3,5,9, then empty=1 and kvo=0.
- **Stable ties:** enq (7,A), then (7,B), then (7,C). Three deqs return A, B, C in that order.
- **Full:** fill with keys 1,2,3,4 and enq key 0.
  - Without macro: rej=1 one cycle later; contents remain 1,2,3,4.
  - With macro: drop=1, contents 0,1,2,3.
  - With macro, enq key 9: rej=1, drop=0.
- **Replace on full:** contents 1,2,3,4; enq (5,X)+deq in one cycle. kvo sampled = key 1; next contents 2,3,4,5; count=4; rej=0.
- **Empty corners:**
  - deq on empty gives rej=1, count=0.
  - enq (4,A)+deq on empty gives rej=1, count=1, kvo={4,A}.
- **Max mode and reset:** MAX_MODE=1, enq keys 2,8,5 gives deq order 8,5,2. Asserting rst in the same cycle as an enq gives count=0 and kvo=0 immediately; no entry is retained.

Source files
------------

// File: rtl/sr_pq_param.sv
// Shift-register priority queue of <key,value> pairs, min- or max-ordered.
// Define SR_PQ_OVERWRITE_EN to let enq on full evict the lowest entry.
module sr_pq_param #(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int CAPACITY  = 4,
  parameter int MAX_MODE  = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]      kvi,
  input  logic                                deq,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]      kvo,
  output logic [$clog2(CAPACITY+1)-1:0]       count,
  output logic                                empty,
  output logic                                full,
  output logic                                rej,
  output logic                                drop
);
  localparam int KVW = KEY_WIDTH + VAL_WIDTH;
  localparam int CW  = $clog2(CAPACITY + 1);

  logic           cv  [CAPACITY];
  logic [KVW-1:0] ckv [CAPACITY];
  logic [CAPACITY:0] ge;
  logic [CW-1:0]  cnt;
  logic           rej_q;
  logic           drop_q;
  logic           ovw_ok;
  logic           do_ins;
  logic           do_deq;
  logic           do_rep;
  logic [KEY_WIDTH-1:0] key_in;

  assign key_in       = kvi[KVW-1:VAL_WIDTH];
  assign ge[CAPACITY] = 1'b0;

  assign full  = (cnt == CW'(CAPACITY));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign kvo   = cv[0] ? ckv[0] : '0;
  assign rej   = rej_q;
  assign drop  = drop_q;

`ifdef SR_PQ_OVERWRITE_EN
  // Newcomer must strictly beat the tail entry to displace it
  assign ovw_ok = !ge[CAPACITY-1];
`else
  assign ovw_ok = 1'b0;
`endif

  assign do_ins = enq && (deq ? empty : (!full || ovw_ok));
  assign do_deq = deq && !enq && !empty;
  assign do_rep = enq && deq && !empty;

  genvar g;
  for (g = 0; g < CAPACITY; g++) begin : g_cell
    logic [KEY_WIDTH-1:0] ck;
    logic           ins_lo;
    logic           rep_lo;
    logic           pv;
    logic           nv;
    logic [KVW-1:0] pkv;
    logic [KVW-1:0] nkv;
    logic           v_d;
    logic [KVW-1:0] kv_d;

    assign ck    = ckv[g][KVW-1:VAL_WIDTH];
    // Thermometer bit: this cell stays ahead of the incoming key
    assign ge[g] = cv[g] &&
      ((MAX_MODE != 0) ? (ck >= key_in) : (ck <= key_in));

    if (g == 0) begin : g_head
      assign ins_lo = 1'b1;
      assign rep_lo = 1'b1;
      assign pv     = 1'b0;
      assign pkv    = '0;
    end else begin : g_body
      assign ins_lo = ge[g-1];
      assign rep_lo = ge[g];
      assign pv     = cv[g-1];
      assign pkv    = ckv[g-1];
    end

    if (g == CAPACITY - 1) begin : g_tail
      assign nv  = 1'b0;
      assign nkv = '0;
    end else begin : g_mid
      assign nv  = cv[g+1];
      assign nkv = ckv[g+1];
    end

    always_comb begin
      v_d  = cv[g];
      kv_d = ckv[g];
      unique case (1'b1)
        do_ins: begin
          if (!ge[g]) begin
            if (ins_lo) begin
              v_d  = 1'b1;
              kv_d = kvi;
            end else begin
              v_d  = pv;
              kv_d = pkv;
            end
          end
        end
        do_deq: begin
          v_d  = nv;
          kv_d = nkv;
        end
        do_rep: begin
          if (ge[g+1]) begin
            v_d  = nv;
            kv_d = nkv;
          end else if (rep_lo) begin
            v_d  = 1'b1;
            kv_d = kvi;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cv[g]  <= 1'b0;
        ckv[g] <= '0;
      end else begin
        cv[g]  <= v_d;
        ckv[g] <= kv_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rej_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      if (do_ins && !full)
        cnt <= cnt + CW'(1);
      else if (do_deq)
        cnt <= cnt - CW'(1);
      rej_q  <= (deq && empty) ||
                (enq && !deq && full && !ovw_ok);
      drop_q <= enq && !deq && full && ovw_ok;
    end
  end
endmodule
